// File: rtl/adc_trigger_pkg.sv
// Shared constants for the ADC trigger sequencer and the comparator core:
// state encodings, configuration widths and the captured-config record.
package adc_trigger_pkg;

    localparam int PRE_W  = 16;
    localparam int EDGE_W = 8;
    localparam int HOLD_W = 16;
    localparam int POST_W = 16;
    localparam int TMO_W  = 24;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_PRETRIG = 3'd2;
    localparam logic [2:0] ST_ARMED   = 3'd3;
    localparam logic [2:0] ST_POST    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef struct packed {
        logic [PRE_W-1:0]  pre;
        logic [EDGE_W-1:0] edge_cnt;
        logic [HOLD_W-1:0] holdoff;
        logic [POST_W-1:0] post;
        logic [TMO_W-1:0]  timeout;
    } trig_cfg_t;

    // A zero edge count still needs one event to trigger.
    function automatic logic [EDGE_W-1:0] eff_edge(input logic [EDGE_W-1:0] n);
        return (n == '0) ? EDGE_W'(1) : n;
    endfunction

endpackage

// File: rtl/adc_trigger_sequencer_if.sv
// Link between the trigger sequencer (master) and the comparator core (slave).
interface adc_trigger_sequencer_if;

    logic comp_sig;
    logic comp_ch_a;
    logic comp_ch_b;
    logic comp_ena;
    logic comp_rst;

    modport master (
        input  comp_sig, comp_ch_a, comp_ch_b,
        output comp_ena, comp_rst
    );

    modport slave (
        output comp_sig, comp_ch_a, comp_ch_b,
        input  comp_ena, comp_rst
    );

endinterface

// File: rtl/adc_trigger_holdoff_timer.sv
// Holdoff down-counter: clear, load, decrement to zero and stop there.
module adc_trigger_holdoff_timer
    import adc_trigger_pkg::*;
(
    input  logic              adc_data_clk,
    input  logic              trig_rst,
    input  logic              clr,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    output logic              zero
);

    logic [HOLD_W-1:0] cnt;

    always_ff @(posedge adc_data_clk) begin
        if (trig_rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - HOLD_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/adc_trigger_sequencer.sv
// ADC trigger sequencer: clears and arms the comparator, counts qualifying
// edges (with holdoff) or times out, then runs the post-trigger window.
// state: IDLE wait arm | CLEAR comp reset | PRETRIG settle | ARMED count | POST tail | DONE hold
module adc_trigger_sequencer
    import adc_trigger_pkg::*;
(
    input  logic                    adc_data_clk,
    input  logic                    trig_rst,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [PRE_W-1:0]        cfg_pre_samples,
    input  logic [EDGE_W-1:0]       cfg_edge_count,
    input  logic [HOLD_W-1:0]       cfg_holdoff,
    input  logic [POST_W-1:0]       cfg_post_samples,
    input  logic [TMO_W-1:0]        cfg_auto_timeout,
    adc_trigger_sequencer_if.master comp,
    output logic                    trig_out,
    output logic                    trig_auto,
    output logic                    trig_ch_a,
    output logic                    trig_ch_b,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              dbg_seq_state
);

    logic [2:0]        state;
    trig_cfg_t         cfg_q;
    logic [PRE_W-1:0]  seq_cnt;
    logic [EDGE_W-1:0] evt_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              prev_sig;
    logic              abort_rst_q;
    logic              hold_zero;
    logic              arm_ok;
    logic              abort_ok;
    logic              in_armed;
    logic              evt_ok;
    logic              evt_hit;
    logic              tmo_hit;
    logic              fire;

    assign arm_ok   = arm && !abort && (state == ST_IDLE || state == ST_DONE);
    assign abort_ok = abort && (state != ST_IDLE);
    assign in_armed = (state == ST_ARMED);
    assign evt_ok   = in_armed && comp.comp_sig && !prev_sig && hold_zero;
    assign evt_hit  = evt_ok && (evt_cnt >= eff_edge(cfg_q.edge_cnt) - EDGE_W'(1));
    assign tmo_hit  = in_armed && (cfg_q.timeout != '0) &&
                      (tmo_cnt == cfg_q.timeout - TMO_W'(1));
    assign fire     = (evt_hit || tmo_hit) && !abort && !trig_rst;

    adc_trigger_holdoff_timer u_holdoff (
        .adc_data_clk (adc_data_clk),
        .trig_rst     (trig_rst),
        .clr          (arm_ok),
        .load         (evt_ok),
        .load_val     (cfg_q.holdoff),
        .zero         (hold_zero)
    );

    always_ff @(posedge adc_data_clk) begin
        if (trig_rst) begin
            state       <= ST_IDLE;
            cfg_q       <= '0;
            seq_cnt     <= '0;
            evt_cnt     <= '0;
            tmo_cnt     <= '0;
            prev_sig    <= 1'b0;
            abort_rst_q <= 1'b0;
            trig_auto   <= 1'b0;
            trig_ch_a   <= 1'b0;
            trig_ch_b   <= 1'b0;
        end else begin
            prev_sig    <= comp.comp_sig;
            abort_rst_q <= abort_ok;
            if (abort_ok) begin
                state <= ST_IDLE;
            end else if (arm_ok) begin
                state     <= ST_CLEAR;
                cfg_q     <= '{cfg_pre_samples, cfg_edge_count, cfg_holdoff,
                               cfg_post_samples, cfg_auto_timeout};
                seq_cnt   <= '0;
                evt_cnt   <= '0;
                tmo_cnt   <= '0;
                trig_auto <= 1'b0;
                trig_ch_a <= 1'b0;
                trig_ch_b <= 1'b0;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        seq_cnt <= '0;
                        state   <= (cfg_q.pre != '0) ? ST_PRETRIG : ST_ARMED;
                    end
                    ST_PRETRIG: begin
                        if (seq_cnt == cfg_q.pre - PRE_W'(1)) begin
                            seq_cnt <= '0;
                            state   <= ST_ARMED;
                        end else begin
                            seq_cnt <= seq_cnt + PRE_W'(1);
                        end
                    end
                    ST_ARMED: begin
                        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (evt_ok && evt_cnt != '1) evt_cnt <= evt_cnt + EDGE_W'(1);
                        // A real edge beats a coincident timeout.
                        if (fire) begin
                            seq_cnt   <= '0;
                            state     <= (cfg_q.post != '0) ? ST_POST : ST_DONE;
                            trig_auto <= !evt_hit;
                            trig_ch_a <= evt_hit && comp.comp_ch_a;
                            trig_ch_b <= evt_hit && comp.comp_ch_b;
                        end
                    end
                    ST_POST: begin
                        if (seq_cnt == cfg_q.post - POST_W'(1)) begin
                            seq_cnt <= '0;
                            state   <= ST_DONE;
                        end else begin
                            seq_cnt <= seq_cnt + POST_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign trig_out      = fire;
    assign comp.comp_ena = in_armed;
    assign comp.comp_rst = trig_rst || (state == ST_CLEAR) || abort_rst_q;
    assign busy          = (state != ST_IDLE) && (state != ST_DONE);
    assign done          = (state == ST_DONE);
    assign dbg_seq_state = state;

endmodule

// File: tb/tb_adc_trigger_sequencer.sv
// Randomized scoreboard bench for adc_trigger_sequencer with an
// event-list reference model of trigger timing and capture.
module tb_adc_trigger_sequencer;
    import adc_trigger_pkg::*;

    logic        adc_data_clk = 1'b0;
    logic        trig_rst = 1'b1;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_pre_samples = '0;
    logic [7:0]  cfg_edge_count = '0;
    logic [15:0] cfg_holdoff = '0;
    logic [15:0] cfg_post_samples = '0;
    logic [23:0] cfg_auto_timeout = '0;
    logic        trig_out, trig_auto, trig_ch_a, trig_ch_b, busy, done;
    logic [2:0]  dbg_seq_state;

    adc_trigger_sequencer_if comp_if ();

    adc_trigger_sequencer dut (
        .adc_data_clk     (adc_data_clk),
        .trig_rst         (trig_rst),
        .arm              (arm),
        .abort            (abort),
        .cfg_pre_samples  (cfg_pre_samples),
        .cfg_edge_count   (cfg_edge_count),
        .cfg_holdoff      (cfg_holdoff),
        .cfg_post_samples (cfg_post_samples),
        .cfg_auto_timeout (cfg_auto_timeout),
        .comp             (comp_if),
        .trig_out         (trig_out),
        .trig_auto        (trig_auto),
        .trig_ch_a        (trig_ch_a),
        .trig_ch_b        (trig_ch_b),
        .busy             (busy),
        .done             (done),
        .dbg_seq_state    (dbg_seq_state)
    );

    always #5 adc_data_clk = ~adc_data_clk;

    int cyc = 0;
    always @(posedge adc_data_clk) cyc <= cyc + 1;

    typedef struct {
        int trig_cyc;
        bit auto_f;
        bit ch_a;
        bit ch_b;
        int done_cyc;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_have = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    bit sig_a[1024];
    bit cha_a[1024];
    bit chb_a[1024];

    function automatic void check(string nm, longint act, longint exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    endfunction

    task automatic tick();
        @(posedge adc_data_clk);
        #1;
    endtask

    task automatic drive_sig(input int o);
        comp_if.comp_sig  = sig_a[o];
        comp_if.comp_ch_a = cha_a[o];
        comp_if.comp_ch_b = chb_a[o];
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 1024; i++) begin
            sig_a[i] = 1'b0;
            cha_a[i] = 1'b0;
            chb_a[i] = 1'b0;
        end
    endtask

    // Monitor: pops an expectation whenever the DUT fires a trigger.
    initial begin
        exp_t cur;
        int   attr_cyc;
        bit   done_d;
        attr_cyc = -1;
        done_d = 1'b0;
        forever begin
            @(negedge adc_data_clk);
            if (trig_out) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_trig", trig_out, 0);
                end else begin
                    cur = sb_q.pop_front();
                    mon_have = 1'b1;
                    check("trig_cycle", cyc, cur.trig_cyc);
                    attr_cyc = cyc + 1;
                end
            end
            if (mon_have && cyc == attr_cyc) begin
                check("trig_auto", trig_auto, cur.auto_f);
                check("trig_ch_a", trig_ch_a, cur.ch_a);
                check("trig_ch_b", trig_ch_b, cur.ch_b);
                if (cur.done_cyc < 0) mon_have = 1'b0;
            end
            if (mon_have && done && !done_d) begin
                check("done_cycle", cyc, cur.done_cyc);
                mon_have = 1'b0;
            end
            done_d = done;
        end
    end

    // kill: 0 none, 1 abort at offset kill_off, 2 trig_rst at offset kill_off
    task automatic run_acq(input int pre, input int ecnt, input int hold, input int post,
                           input int tmo, input int len, input bit glitch,
                           input int kill, input int kill_off);
        int   s, cnt, last, trig, eff, end_off, last_o, a0;
        bit   auto_f, glitch_ok;
        exp_t e;
        s = 2 + pre;
        eff = (ecnt == 0) ? 1 : ecnt;
        cnt = 0;
        last = -100000;
        trig = -1;
        auto_f = 1'b0;
        for (int o = s; o < len && trig < 0; o++) begin
            if (sig_a[o] && !sig_a[o-1] && (o - last) > hold) begin
                cnt++;
                last = o;
                if (cnt >= eff) trig = o;
            end
            if (trig < 0 && tmo != 0 && (o - s + 1) == tmo) begin
                trig = o;
                auto_f = 1'b1;
            end
        end
        if (kill != 0 && trig >= kill_off) trig = -1;
        end_off = (kill != 0) ? kill_off : ((trig >= 0) ? trig + post + 2 : len);
        last_o = (kill != 0) ? end_off - 1 : end_off;
        glitch_ok = glitch && (trig < 0 || trig > s + 2) && (last_o > s + 2);

        tick();
        a0 = cyc;
        if (trig >= 0) begin
            e.trig_cyc = a0 + trig;
            e.auto_f   = auto_f;
            e.ch_a     = auto_f ? 1'b0 : cha_a[trig];
            e.ch_b     = auto_f ? 1'b0 : chb_a[trig];
            e.done_cyc = (kill != 0) ? -1 : a0 + trig + post + 1;
            sb_q.push_back(e);
        end
        arm = 1'b1;
        cfg_pre_samples  = 16'(pre);
        cfg_edge_count   = 8'(ecnt);
        cfg_holdoff      = 16'(hold);
        cfg_post_samples = 16'(post);
        cfg_auto_timeout = 24'(tmo);
        drive_sig(0);

        for (int o = 1; o <= last_o; o++) begin
            tick();
            arm = glitch_ok && (o == s + 1);
            cfg_pre_samples  = 16'($urandom);
            cfg_edge_count   = 8'($urandom);
            cfg_holdoff      = 16'($urandom);
            cfg_post_samples = 16'($urandom);
            cfg_auto_timeout = 24'($urandom);
            drive_sig(o);
            @(negedge adc_data_clk);
            if (o == 1) begin
                check("clear_state", dbg_seq_state, ST_CLEAR);
                check("clear_comp_rst", comp_if.comp_rst, 1);
                check("clear_comp_ena", comp_if.comp_ena, 0);
            end
            if (o == 2 && pre > 0) begin
                check("pretrig_state", dbg_seq_state, ST_PRETRIG);
                check("pretrig_comp_ena", comp_if.comp_ena, 0);
            end
            if (o == s) begin
                check("armed_state", dbg_seq_state, ST_ARMED);
                check("armed_comp_ena", comp_if.comp_ena, 1);
                check("armed_busy", busy, 1);
            end
            if (glitch_ok && o == s + 2) check("arm_while_armed", dbg_seq_state, ST_ARMED);
            if (kill == 0 && trig >= 0 && o == end_off) begin
                check("done_state", dbg_seq_state, ST_DONE);
                check("done_busy", busy, 0);
            end
        end
        arm = 1'b0;

        if (kill == 2) begin
            tick();
            trig_rst = 1'b1;
            drive_sig(end_off);
            @(negedge adc_data_clk);
            check("rst_comp_rst_high", comp_if.comp_rst, 1);
            check("rst_no_trig", trig_out, 0);
            tick();
            trig_rst = 1'b0;
            @(negedge adc_data_clk);
            check("rst_state", dbg_seq_state, ST_IDLE);
            check("rst_comp_ena", comp_if.comp_ena, 0);
            check("rst_comp_rst_low", comp_if.comp_rst, 0);
            check("rst_busy_done", {busy, done}, 0);
            check("rst_trig_flags", {trig_auto, trig_ch_a, trig_ch_b}, 0);
        end else if (kill == 1 || trig < 0) begin
            tick();
            abort = 1'b1;
            drive_sig(end_off);
            @(negedge adc_data_clk);
            check("abort_no_trig", trig_out, 0);
            tick();
            abort = 1'b0;
            @(negedge adc_data_clk);
            check("abort_state", dbg_seq_state, ST_IDLE);
            check("abort_comp_ena", comp_if.comp_ena, 0);
            check("abort_comp_rst_pulse", comp_if.comp_rst, 1);
            tick();
            @(negedge adc_data_clk);
            check("abort_comp_rst_end", comp_if.comp_rst, 0);
        end
        comp_if.comp_sig = 1'b0;
        comp_if.comp_ch_a = 1'b0;
        comp_if.comp_ch_b = 1'b0;
        for (int i = 0; i < 50 && (sb_q.size() != 0 || mon_have); i++) @(negedge adc_data_clk);
        if (sb_q.size() != 0 || mon_have) check("scoreboard_drain", sb_q.size() + int'(mon_have), 0);
    endtask

    initial begin
        int pre, ecnt, hold, post, tmo, dens, len, s;
        comp_if.comp_sig = 1'b0;
        comp_if.comp_ch_a = 1'b0;
        comp_if.comp_ch_b = 1'b0;
        @(negedge adc_data_clk);
        check("reset_comp_rst", comp_if.comp_rst, 1);
        tick();
        tick();
        trig_rst = 1'b0;
        @(negedge adc_data_clk);
        check("reset_state", dbg_seq_state, ST_IDLE);
        check("reset_outputs", {comp_if.comp_ena, comp_if.comp_rst, trig_out, trig_auto,
                                trig_ch_a, trig_ch_b, busy, done}, 0);

        // edge=1, post=4: trigger on the 10th ARMED cycle, arm pulse while armed
        clear_stim();
        sig_a[11] = 1'b1;
        cha_a[11] = 1'b1;
        run_acq(0, 1, 0, 4, 0, 60, 1'b1, 0, 0);

        // edge=3, holdoff=5, rising edge every 2 cycles
        clear_stim();
        for (int o = 3; o < 200; o += 2) sig_a[o] = 1'b1;
        chb_a[15] = 1'b1;
        run_acq(1, 3, 5, 2, 0, 200, 1'b0, 0, 0);

        // forced trigger on ARMED cycle 100 with channel flags held high
        clear_stim();
        for (int i = 0; i < 1024; i++) begin
            cha_a[i] = 1'b1;
            chb_a[i] = 1'b1;
        end
        run_acq(2, 1, 0, 1, 100, 2 + 2 + 105, 1'b0, 0, 0);

        // edge coincident with timeout expiry
        clear_stim();
        sig_a[21] = 1'b1;
        chb_a[21] = 1'b1;
        run_acq(0, 1, 0, 0, 20, 60, 1'b0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            pre  = $urandom_range(0, 5);
            ecnt = $urandom_range(0, 4);
            hold = $urandom_range(0, 6);
            post = $urandom_range(0, 5);
            tmo  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 80);
            dens = $urandom_range(10, 60);
            s    = 2 + pre;
            len  = (tmo != 0) ? s + tmo + 3 : s + 120;
            clear_stim();
            for (int o = s - 1; o < len + 2; o++) begin
                sig_a[o] = ($urandom_range(0, 99) < dens);
                cha_a[o] = 1'($urandom);
                chb_a[o] = 1'($urandom);
            end
            run_acq(pre, ecnt, hold, post, tmo, len, 1'($urandom), 0, 0);
        end

        // abort in PRETRIG with a would-be trigger edge later on
        clear_stim();
        sig_a[55] = 1'b1;
        run_acq(50, 1, 0, 2, 0, 100, 1'b0, 1, 12);

        // trig_rst in the middle of POST
        clear_stim();
        sig_a[5] = 1'b1;
        cha_a[5] = 1'b1;
        run_acq(0, 1, 0, 40, 0, 60, 1'b0, 2, 8);

        clear_stim();
        sig_a[4] = 1'b1;
        sig_a[6] = 1'b1;
        run_acq(0, 2, 0, 3, 0, 40, 1'b0, 0, 0);

        check("final_queue_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_trigger_sequencer.md
ADC_TRIGGER_SEQUENCER -- requirements
Module: adc_trigger_sequencer

Interface
REQ-001 adc_data_clk  in  1  sole clock; all logic on rising edge.
REQ-002 trig_rst  in  1  synchronous, active-high reset.
REQ-003 arm  in  1  single-cycle request to start an acquisition; honoured only in IDLE or DONE.
REQ-004 abort  in  1  single-cycle request to cancel; honoured in every state except IDLE.
REQ-005 cfg_pre_samples  in  16  cycles to wait after clear before enabling the comparator; 0 skips the wait.
REQ-006 cfg_edge_count  in  8  qualifying events required to trigger; 0 treated as 1.
REQ-007 cfg_holdoff  in  16  cycles after each counted event during which further events are ignored.
REQ-008 cfg_post_samples  in  16  cycles from trigger to done; 0 gives done on the next cycle.
REQ-009 cfg_auto_timeout  in  24  cycles in ARMED before a forced trigger; 0 disables the forced trigger.
REQ-010 comp_sig  in  1  polarity-applied toggle output of the comparator core.
REQ-011 comp_ch_a, comp_ch_b  in  1 each  channel flags from the comparator core.
REQ-012 comp_ena  out  1  comparator enable.
REQ-013 comp_rst  out  1  comparator reset.
REQ-014 trig_out  out  1  one-cycle pulse on trigger.
REQ-015 trig_auto  out  1  high if the last trigger was forced; held until the next arm.
REQ-016 trig_ch_a, trig_ch_b  out  1 each  comp_ch_a/comp_ch_b captured at trigger; both 0 for a forced trigger.
REQ-017 busy  out  1  high in every state except IDLE and DONE.
REQ-018 done  out  1  high in DONE only.
REQ-019 dbg_seq_state  out  3  current state encoding.

Function
REQ-020 States (encoding): IDLE=0, CLEAR=1, PRETRIG=2, ARMED=3, POST=4, DONE=5.
REQ-021 All cfg_* inputs are captured into internal registers on the cycle arm is accepted; later changes have no effect until the next arm.
REQ-022 Arm accepted in IDLE or DONE: next state CLEAR, trig_auto cleared, event/holdoff/timeout counters cleared.
REQ-023 CLEAR lasts exactly 1 cycle with comp_rst=1 and comp_ena=0; next state PRETRIG if captured pre>0, else ARMED.
REQ-024 PRETRIG lasts exactly captured pre cycles with comp_ena=0; next state ARMED.
REQ-025 ARMED drives comp_ena=1; in every other state comp_ena=0.
REQ-026 Qualifying event: comp_sig=1 while the registered previous comp_sig=0, detected in ARMED only; the previous-value register updates every cycle in every state.
REQ-027 Event outside holdoff: event counter increments and the holdoff counter loads captured holdoff; events while the holdoff counter is nonzero are ignored, and the counter decrements by 1 per cycle.
REQ-028 When the event counter reaches the effective edge count, in the same cycle: trig_out=1, trig_ch_a/trig_ch_b captured, next state POST.
REQ-029 Timeout counter increments every ARMED cycle; when it equals a nonzero captured timeout, force a trigger: trig_out=1, trig_auto=1, trig_ch_a/trig_ch_b=0, next state POST.
REQ-030 A qualifying trigger event and timeout expiry in the same cycle: the event wins and trig_auto=0.
REQ-031 POST counts captured post cycles, then enters DONE; with post=0, DONE follows 1 cycle after the trigger.
REQ-032 DONE is held until arm (re-arm through CLEAR) or trig_rst.
REQ-033 Abort in CLEAR, PRETRIG, ARMED, POST or DONE: next state IDLE; comp_ena drops next cycle; comp_rst=1 for 1 cycle; no trig_out.
REQ-034 Arm and abort in the same cycle: abort wins.
REQ-035 Arm while busy is ignored.
REQ-036 All counters saturate and never wrap; widths equal their cfg widths.

Reset
REQ-037 trig_rst at any cycle, including mid-operation: state IDLE, all counters 0, comp_ena=0, comp_rst=1 during reset and 0 after, trig_out=0, trig_auto=0, trig_ch_a=0, trig_ch_b=0, busy=0, done=0, previous-value register=0.

Structure
REQ-038 State encodings and cfg widths are defined as constants in a shared adc_trigger package, which the comparator core also uses.
REQ-039 One sub-module, adc_trigger_holdoff_timer (load/decrement/zero flag), is instantiated for the holdoff counter; all other logic is in one always block plus output assigns.

Verification
REQ-040 pre=0, edge=1, post=4, timeout=0; arm, then rising comp_sig 10 cycles into ARMED -> trig_out same cycle, done 5 cycles later, trig_auto=0.
REQ-041 edge=3, holdoff=5; rising edges every 2 cycles -> only events 2+ cycles clear of holdoff are counted; trigger on the 3rd counted event.
REQ-042 timeout=100, no events -> forced trigger at ARMED cycle 100, trig_auto=1, trig_ch_a=trig_ch_b=0.
REQ-043 Rising edge coincident with timeout expiry, comp_ch_b=1 -> trig_auto=0, trig_ch_b=1.
REQ-044 Abort during PRETRIG (pre=50), and separately trig_rst during POST -> IDLE next cycle, comp_ena=0, no trig_out, comp_rst pulse.
REQ-045 Arm while ARMED, and cfg changed after arm -> arm ignored and captured cfg used; arm from DONE restarts via CLEAR.
